mem_port_arbiter: RTL and testbench

Arbiter and sequencer that shares the single-ported memory between the instruction-fetch stage and the load/store path of the RISC-V core. It accepts one request at a time from either side and holds it stable on the memory port until acknowledged. It returns the read data to the owner with a one-cycle valid pulse. It also discards in-flight fetch responses when the core redirects the PC on a taken branch or jump.

---
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch and the
// load/store path. One access is outstanding at a time; the granted
// payload is registered onto the memory port and held until mem_ack.
// Data normally wins contention, but after MAX_DATA_STREAK contended
// data grants a waiting fetch is forced through. A PC redirect
// (ifetch_flush) silently drops an in-flight fetch response.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    ifetch_req,
    input  logic [ADDR_WIDTH-1:0]   ifetch_addr,
    input  logic                    ifetch_flush,
    output logic                    ifetch_ready,
    output logic                    ifetch_valid,
    output logic [DATA_WIDTH-1:0]   ifetch_rdata,

    input  logic                    dmem_req,
    input  logic                    dmem_we,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata,
    input  logic [DATA_WIDTH/8-1:0] dmem_wmask,
    output logic                    dmem_ready,
    output logic                    dmem_valid,
    output logic [DATA_WIDTH-1:0]   dmem_rdata,

    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int MASK_WIDTH   = DATA_WIDTH / 8;
    localparam int STREAK_WIDTH = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_WIDTH-1:0] STREAK_LIMIT = STREAK_WIDTH'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [STREAK_WIDTH-1:0] streak;
    logic                    drop;
    logic                    fetch_eligible;
    logic                    grant_i;
    logic                    grant_d;

    // A redirect in the same cycle makes the fetch address stale, so it is not granted.
    assign fetch_eligible = ifetch_req & ~ifetch_flush;

    assign ifetch_ready = grant_i;
    assign dmem_ready   = grant_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: leave IDLE on a grant, return on the memory acknowledge.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = BUSY_D;
                end else if (grant_i) begin
                    state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant decode: data first unless a waiting fetch has been starved for the full streak.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE && rst_n) begin
            if (dmem_req && !(fetch_eligible && streak == STREAK_LIMIT)) begin
                grant_d = 1'b1;
            end else if (fetch_eligible) begin
                grant_i = 1'b1;
            end
        end
    end

    // Starvation counter: counts data grants that beat a waiting fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (grant_d) begin
            if (!fetch_eligible) begin
                streak <= '0;
            end else if (streak != STREAK_LIMIT) begin
                streak <= streak + STREAK_WIDTH'(1);
            end
        end else if (grant_i) begin
            streak <= '0;
        end
    end

    // Drop flag: remembers a redirect seen while the fetch was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop <= 1'b0;
        end else if (state == BUSY_I && !mem_ack) begin
            drop <= drop | ifetch_flush;
        end else begin
            drop <= 1'b0;
        end
    end

    // Memory port: load the winner's payload on grant, hold it until acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= dmem_we;
            mem_addr  <= dmem_addr;
            mem_wdata <= dmem_wdata;
            mem_wmask <= dmem_wmask;
        end else if (grant_i) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= ifetch_addr;
            mem_wdata <= '0;
            mem_wmask <= MASK_WIDTH'(0);
        end else if (state != IDLE && mem_ack) begin
            mem_req   <= 1'b0;
        end
    end

    // Response path: one-cycle valid to the owner, read data captured with the acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifetch_valid <= 1'b0;
            ifetch_rdata <= '0;
            dmem_valid   <= 1'b0;
            dmem_rdata   <= '0;
        end else begin
            ifetch_valid <= 1'b0;
            dmem_valid   <= 1'b0;
            if (state == BUSY_I && mem_ack && !drop && !ifetch_flush) begin
                ifetch_valid <= 1'b1;
                ifetch_rdata <= mem_rdata;
            end
            if (state == BUSY_D && mem_ack) begin
                dmem_valid <= 1'b1;
                if (!mem_we) begin
                    dmem_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios for the arbiter followed by a randomized run checked
// against a transaction-level model (one outstanding access, a word memory
// array and a starvation count derived from the arbitration rules).
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MW   = DW / 8;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ifetch_req = 1'b0;
    logic [AW-1:0] ifetch_addr = '0;
    logic          ifetch_flush = 1'b0;
    logic          ifetch_ready;
    logic          ifetch_valid;
    logic [DW-1:0] ifetch_rdata;
    logic          dmem_req = 1'b0;
    logic          dmem_we = 1'b0;
    logic [AW-1:0] dmem_addr = '0;
    logic [DW-1:0] dmem_wdata = '0;
    logic [MW-1:0] dmem_wmask = '0;
    logic          dmem_ready;
    logic          dmem_valid;
    logic [DW-1:0] dmem_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    logic          zero_wait = 1'b0;
    logic          ack_drv = 1'b0;
    logic [DW-1:0] rdata_drv = '0;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        bit            is_data;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
        bit            dropped;
    } txn_t;

    logic [DW-1:0] mem_model [64];

    assign mem_ack   = zero_wait ? mem_req : ack_drv;
    assign mem_rdata = rdata_drv;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_DATA_STREAK(MAXS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ifetch_req(ifetch_req),
        .ifetch_addr(ifetch_addr),
        .ifetch_flush(ifetch_flush),
        .ifetch_ready(ifetch_ready),
        .ifetch_valid(ifetch_valid),
        .ifetch_rdata(ifetch_rdata),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_wmask(dmem_wmask),
        .dmem_ready(dmem_ready),
        .dmem_valid(dmem_valid),
        .dmem_rdata(dmem_rdata),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        ifetch_req = 1'b1;
        dmem_req   = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        tests_run++; if ({ifetch_ready, dmem_ready} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b want 00", {ifetch_ready, dmem_ready}); end
        tests_run++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask} !== '0) begin tests_failed++; $display("[TB] FAIL reset_mem: req=%b we=%b addr=%h wdata=%h wmask=%h want all 0", mem_req, mem_we, mem_addr, mem_wdata, mem_wmask); end
        tests_run++; if ({ifetch_valid, ifetch_rdata, dmem_valid, dmem_rdata} !== '0) begin tests_failed++; $display("[TB] FAIL reset_resp: iv=%b ird=%h dv=%b drd=%h want all 0", ifetch_valid, ifetch_rdata, dmem_valid, dmem_rdata); end
        tick;
        ifetch_req = 1'b0;
        dmem_req   = 1'b0;
        rst_n      = 1'b1;
        #1;
        tests_run++; if ({ifetch_ready, dmem_ready, mem_req} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_release_idle: got %b want 000", {ifetch_ready, dmem_ready, mem_req}); end
    endtask

    task automatic test_single_fetch;
        tick;
        ifetch_req  = 1'b1;
        ifetch_addr = 32'h100;
        #1;
        tests_run++; if ({ifetch_ready, dmem_ready} !== 2'b10) begin tests_failed++; $display("[TB] FAIL fetch_grant: ready i/d got %b want 10", {ifetch_ready, dmem_ready}); end
        for (int i = 1; i <= 3; i++) begin
            tick;
            ifetch_req = 1'b0;
            ack_drv    = (i == 3);
            rdata_drv  = (i == 3) ? 32'h00500093 : $urandom;
            #1;
            tests_run++; if ({mem_req, mem_we, mem_wmask, mem_addr} !== {1'b1, 1'b0, 4'h0, 32'h100}) begin tests_failed++; $display("[TB] FAIL fetch_hold%0d: req=%b we=%b wmask=%h addr=%h want 1 0 0 00000100", i, mem_req, mem_we, mem_wmask, mem_addr); end
            tests_run++; if ({ifetch_valid, ifetch_ready, dmem_ready} !== 3'b000) begin tests_failed++; $display("[TB] FAIL fetch_busy%0d: valid/ready got %b want 000", i, {ifetch_valid, ifetch_ready, dmem_ready}); end
        end
        tick;
        ack_drv = 1'b0;
        #1;
        tests_run++; if ({ifetch_valid, ifetch_rdata, mem_req} !== {1'b1, 32'h00500093, 1'b0}) begin tests_failed++; $display("[TB] FAIL fetch_resp: valid=%b rdata=%h mem_req=%b want 1 00500093 0", ifetch_valid, ifetch_rdata, mem_req); end
        tick;
        #1;
        tests_run++; if ({ifetch_valid, ifetch_rdata} !== {1'b0, 32'h00500093}) begin tests_failed++; $display("[TB] FAIL fetch_pulse_end: valid=%b rdata=%h want 0 00500093", ifetch_valid, ifetch_rdata); end
    endtask

    task automatic test_store;
        tick;
        dmem_req   = 1'b1;
        dmem_we    = 1'b1;
        dmem_addr  = 32'h2004;
        dmem_wdata = 32'hDEADBEEF;
        dmem_wmask = 4'b0011;
        #1;
        tests_run++; if ({ifetch_ready, dmem_ready} !== 2'b01) begin tests_failed++; $display("[TB] FAIL store_grant: ready i/d got %b want 01", {ifetch_ready, dmem_ready}); end
        tick;
        dmem_req  = 1'b0;
        ack_drv   = 1'b1;
        rdata_drv = 32'hA5A55A5A;
        #1;
        tests_run++; if ({mem_req, mem_we, mem_wmask, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hDEADBEEF}) begin tests_failed++; $display("[TB] FAIL store_payload: req=%b we=%b wmask=%b addr=%h wdata=%h", mem_req, mem_we, mem_wmask, mem_addr, mem_wdata); end
        tick;
        ack_drv = 1'b0;
        #1;
        tests_run++; if ({dmem_valid, dmem_rdata, mem_req} !== {1'b1, 32'h0, 1'b0}) begin tests_failed++; $display("[TB] FAIL store_resp: valid=%b rdata=%h mem_req=%b want 1 00000000 0", dmem_valid, dmem_rdata, mem_req); end
        tick;
        #1;
        tests_run++; if (dmem_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL store_pulse_end: valid=%b want 0", dmem_valid); end
        dmem_we = 1'b0;
    endtask

    task automatic test_back_to_back;
        bit want_fetch;
        tick;
        zero_wait  = 1'b1;
        ifetch_req = 1'b1;
        ifetch_addr = 32'h40;
        dmem_req   = 1'b1;
        dmem_we    = 1'b0;
        dmem_addr  = 32'h80;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick;
            rdata_drv = $urandom;
            #1;
            if (k % 2 == 0) begin
                want_fetch = ((k / 2) % (MAXS + 1)) == MAXS;
                tests_run++; if ({ifetch_ready, dmem_ready} !== {want_fetch, !want_fetch}) begin tests_failed++; $display("[TB] FAIL b2b_grant%0d: ready i/d got %b want %b", k / 2, {ifetch_ready, dmem_ready}, {want_fetch, !want_fetch}); end
            end else begin
                tests_run++; if ({ifetch_ready, dmem_ready} !== 2'b00) begin tests_failed++; $display("[TB] FAIL b2b_busy%0d: ready i/d got %b want 00", k, {ifetch_ready, dmem_ready}); end
            end
        end
        tick;
        ifetch_req = 1'b0;
        dmem_req   = 1'b0;
        zero_wait  = 1'b0;
        tick;
    endtask

    task automatic test_flush;
        // baseline fetch so the "unchanged" value is known
        tick;
        ifetch_req  = 1'b1;
        ifetch_addr = 32'h2FC;
        tick;
        ifetch_req = 1'b0;
        ack_drv    = 1'b1;
        rdata_drv  = 32'h00110001;
        tick;
        ack_drv = 1'b0;
        #1;
        tests_run++; if ({ifetch_valid, ifetch_rdata} !== {1'b1, 32'h00110001}) begin tests_failed++; $display("[TB] FAIL flush_baseline: valid=%b rdata=%h want 1 00110001", ifetch_valid, ifetch_rdata); end
        // redirect while the fetch is outstanding
        tick;
        ifetch_req  = 1'b1;
        ifetch_addr = 32'h300;
        #1;
        tests_run++; if (ifetch_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_busy_grant: ready=%b want 1", ifetch_ready); end
        tick;
        ifetch_req   = 1'b0;
        ifetch_flush = 1'b1;
        #1;
        tests_run++; if ({mem_req, mem_addr} !== {1'b1, 32'h300}) begin tests_failed++; $display("[TB] FAIL flush_busy_hold: req=%b addr=%h want 1 00000300", mem_req, mem_addr); end
        tick;
        ifetch_flush = 1'b0;
        ack_drv      = 1'b1;
        rdata_drv    = 32'hBAD00001;
        tick;
        ack_drv = 1'b0;
        #1;
        tests_run++; if ({ifetch_valid, ifetch_rdata, mem_req} !== {1'b0, 32'h00110001, 1'b0}) begin tests_failed++; $display("[TB] FAIL flush_busy_drop: valid=%b rdata=%h mem_req=%b want 0 00110001 0", ifetch_valid, ifetch_rdata, mem_req); end
        // redirect in the acknowledge cycle
        tick;
        ifetch_req  = 1'b1;
        ifetch_addr = 32'h304;
        #1;
        tests_run++; if (ifetch_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_ack_grant: ready=%b want 1", ifetch_ready); end
        tick;
        ifetch_req   = 1'b0;
        ifetch_flush = 1'b1;
        ack_drv      = 1'b1;
        rdata_drv    = 32'hBAD00002;
        tick;
        ifetch_flush = 1'b0;
        ack_drv      = 1'b0;
        #1;
        tests_run++; if ({ifetch_valid, ifetch_rdata} !== {1'b0, 32'h00110001}) begin tests_failed++; $display("[TB] FAIL flush_ack_drop: valid=%b rdata=%h want 0 00110001", ifetch_valid, ifetch_rdata); end
        // the next fetch is delivered normally
        tick;
        ifetch_req  = 1'b1;
        ifetch_addr = 32'h200;
        #1;
        tests_run++; if (ifetch_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_next_grant: ready=%b want 1", ifetch_ready); end
        tick;
        ifetch_req = 1'b0;
        ack_drv    = 1'b1;
        rdata_drv  = 32'h00000513;
        tick;
        ack_drv = 1'b0;
        #1;
        tests_run++; if ({ifetch_valid, ifetch_rdata} !== {1'b1, 32'h00000513}) begin tests_failed++; $display("[TB] FAIL flush_next_resp: valid=%b rdata=%h want 1 00000513", ifetch_valid, ifetch_rdata); end
    endtask

    task automatic test_flush_idle;
        tick;
        ifetch_req   = 1'b1;
        ifetch_flush = 1'b1;
        ifetch_addr  = 32'h400;
        #1;
        tests_run++; if ({ifetch_ready, dmem_ready} !== 2'b00) begin tests_failed++; $display("[TB] FAIL flush_idle_nogrant: ready i/d got %b want 00", {ifetch_ready, dmem_ready}); end
        tick;
        ifetch_flush = 1'b0;
        #1;
        tests_run++; if ({ifetch_ready, mem_req} !== 2'b10) begin tests_failed++; $display("[TB] FAIL flush_idle_grant: ready=%b mem_req=%b want 1 0", ifetch_ready, mem_req); end
        tick;
        ifetch_req = 1'b0;
        ack_drv    = 1'b1;
        rdata_drv  = 32'h00C00113;
        tick;
        ack_drv = 1'b0;
        #1;
        tests_run++; if ({ifetch_valid, ifetch_rdata} !== {1'b1, 32'h00C00113}) begin tests_failed++; $display("[TB] FAIL flush_idle_resp: valid=%b rdata=%h want 1 00C00113", ifetch_valid, ifetch_rdata); end
    endtask

    task automatic test_reset_mid;
        tick;
        zero_wait   = 1'b1;
        ifetch_req  = 1'b1;
        ifetch_addr = 32'h500;
        dmem_req    = 1'b1;
        dmem_we     = 1'b0;
        dmem_addr   = 32'h84;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) tick;
            #1;
        end
        tests_run++; if (dmem_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_fourth_data: dmem_ready=%b want 1", dmem_ready); end
        tick;
        zero_wait = 1'b0;
        ack_drv   = 1'b0;
        #1;
        tests_run++; if ({mem_req, mem_addr} !== {1'b1, 32'h84}) begin tests_failed++; $display("[TB] FAIL rstmid_busy: req=%b addr=%h want 1 00000084", mem_req, mem_addr); end
        rst_n = 1'b0;
        #1;
        tests_run++; if ({ifetch_ready, dmem_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, ifetch_valid, ifetch_rdata, dmem_valid, dmem_rdata} !== '0) begin tests_failed++; $display("[TB] FAIL rstmid_outputs: ir=%b dr=%b req=%b addr=%h ird=%h drd=%h want all 0", ifetch_ready, dmem_ready, mem_req, mem_addr, ifetch_rdata, dmem_rdata); end
        tick;
        ack_drv   = 1'b1;
        rdata_drv = $urandom;
        #1;
        tests_run++; if ({dmem_valid, mem_req} !== 2'b00) begin tests_failed++; $display("[TB] FAIL rstmid_hold: dmem_valid=%b mem_req=%b want 0 0", dmem_valid, mem_req); end
        tick;
        ack_drv = 1'b0;
        rst_n   = 1'b1;
        #1;
        tests_run++; if ({ifetch_ready, dmem_ready, dmem_valid} !== 3'b010) begin tests_failed++; $display("[TB] FAIL rstmid_release_grant: ready i/d valid got %b want 010", {ifetch_ready, dmem_ready, dmem_valid}); end
        tick;
        ifetch_req = 1'b0;
        dmem_req   = 1'b0;
        ack_drv    = 1'b1;
        tick;
        ack_drv = 1'b0;
        tick;
    endtask

    task automatic test_random;
        txn_t          cur;
        bit            busy_m;
        int            streak_m;
        bit            exp_iv, exp_dv;
        logic [DW-1:0] exp_ird, exp_drd;
        bit            fetch_ok, want_i, want_d, drop_i, drop_d;
        int            idx;

        for (int w = 0; w < 64; w++) mem_model[w] = $urandom;
        ifetch_req = 1'b0; dmem_req = 1'b0; ifetch_flush = 1'b0; ack_drv = 1'b0; zero_wait = 1'b0;
        rst_n = 1'b0;
        tick;
        rst_n    = 1'b1;
        busy_m   = 1'b0;
        streak_m = 0;
        exp_iv   = 1'b0; exp_dv = 1'b0;
        exp_ird  = '0;   exp_drd = '0;
        drop_i   = 1'b0; drop_d = 1'b0;
        cur      = '{default: '0};

        for (int c = 0; c < 600; c++) begin
            tick;
            if (drop_i) ifetch_req = 1'b0;
            if (drop_d) dmem_req = 1'b0;
            drop_i = 1'b0;
            drop_d = 1'b0;
            if (!ifetch_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    ifetch_req  = 1'b1;
                    ifetch_addr = 32'($urandom_range(0, 63)) << 2;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                ifetch_req = 1'b0;
            end
            if (!dmem_req) begin
                if ($urandom_range(0, 1) == 0) begin
                    dmem_req   = 1'b1;
                    dmem_we    = 1'($urandom_range(0, 1));
                    dmem_addr  = 32'($urandom_range(0, 63)) << 2;
                    dmem_wdata = $urandom;
                    dmem_wmask = 4'($urandom_range(0, 15));
                end
            end else if ($urandom_range(0, 15) == 0) begin
                dmem_req = 1'b0;
            end
            ifetch_flush = ($urandom_range(0, 9) == 0);
            ack_drv = busy_m && ($urandom_range(0, 2) == 0);
            idx = int'(cur.addr[7:2]);
            rdata_drv = (ack_drv && !cur.we) ? mem_model[idx] : $urandom;
            #1;

            fetch_ok = ifetch_req && !ifetch_flush;
            want_d   = !busy_m && dmem_req && !(fetch_ok && streak_m == MAXS);
            want_i   = !busy_m && fetch_ok && !want_d;

            tests_run++; if ({ifetch_ready, dmem_ready} !== {want_i, want_d}) begin tests_failed++; $display("[TB] FAIL rnd_ready c%0d: i/d got %b want %b", c, {ifetch_ready, dmem_ready}, {want_i, want_d}); end
            tests_run++; if ({ifetch_valid, dmem_valid} !== {exp_iv, exp_dv}) begin tests_failed++; $display("[TB] FAIL rnd_valid c%0d: i/d got %b want %b", c, {ifetch_valid, dmem_valid}, {exp_iv, exp_dv}); end
            tests_run++; if ({ifetch_rdata, dmem_rdata} !== {exp_ird, exp_drd}) begin tests_failed++; $display("[TB] FAIL rnd_rdata c%0d: i=%h d=%h want i=%h d=%h", c, ifetch_rdata, dmem_rdata, exp_ird, exp_drd); end
            tests_run++; if (mem_req !== busy_m) begin tests_failed++; $display("[TB] FAIL rnd_mem_req c%0d: got %b want %b", c, mem_req, busy_m); end
            if (busy_m) begin
                tests_run++; if ({mem_we, mem_addr, mem_wmask} !== {cur.we, cur.addr, cur.wmask} || (cur.we && mem_wdata !== cur.wdata)) begin tests_failed++; $display("[TB] FAIL rnd_payload c%0d: we=%b addr=%h mask=%h wdata=%h want %b %h %h %h", c, mem_we, mem_addr, mem_wmask, mem_wdata, cur.we, cur.addr, cur.wmask, cur.wdata); end
            end

            exp_iv = 1'b0;
            exp_dv = 1'b0;
            if (busy_m) begin
                if (!cur.is_data && ifetch_flush) cur.dropped = 1'b1;
                if (ack_drv) begin
                    busy_m = 1'b0;
                    if (cur.is_data) begin
                        exp_dv = 1'b1;
                        if (cur.we) begin
                            for (int b = 0; b < MW; b++)
                                if (cur.wmask[b]) mem_model[idx][8*b +: 8] = cur.wdata[8*b +: 8];
                        end else begin
                            exp_drd = rdata_drv;
                        end
                    end else if (!cur.dropped) begin
                        exp_iv  = 1'b1;
                        exp_ird = rdata_drv;
                    end
                end
            end else if (want_d) begin
                cur = '{is_data: 1'b1, we: dmem_we, addr: dmem_addr, wdata: dmem_wdata, wmask: dmem_wmask, dropped: 1'b0};
                busy_m   = 1'b1;
                drop_d   = 1'b1;
                streak_m = fetch_ok ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
            end else if (want_i) begin
                cur = '{is_data: 1'b0, we: 1'b0, addr: ifetch_addr, wdata: '0, wmask: '0, dropped: 1'b0};
                busy_m   = 1'b1;
                drop_i   = 1'b1;
                streak_m = 0;
            end
        end
        ifetch_req   = 1'b0;
        dmem_req     = 1'b0;
        ifetch_flush = 1'b0;
        ack_drv      = 1'b0;
    endtask

    // Sequence the scenarios and report.
    initial begin
        test_reset;
        test_single_fetch;
        test_store;
        test_back_to_back;
        test_flush;
        test_flush_idle;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Bound the whole run in case the design stops responding.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
        $fatal(1, "[TB] timeout");
    end

endmodule
